// File: rtl/move_wide_sequencer_pkg.sv
// Shared encodings for the move-wide sequencer: ALU/PC function codes,
// opcode values, FSM state encoding and the debug view of the sequencer.
package cu_pkg;

    localparam logic [4:0] ALU_FS_AND = 5'b000_00;
    localparam logic [4:0] ALU_FS_OR  = 5'b001_00;

    localparam logic [1:0] PC_FS_HOLD = 2'b00;
    localparam logic [1:0] PC_FS_INC  = 2'b01;

    localparam logic [4:0] ZR_ADDR = 5'd31;

    localparam logic [1:0] OPC_MOVN = 2'b00;
    localparam logic [1:0] OPC_RSVD = 2'b01;
    localparam logic [1:0] OPC_MOVZ = 2'b10;
    localparam logic [1:0] OPC_MOVK = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MASK   = 2'd1,
        S_INSERT = 2'd2,
        S_ERROR  = 2'd3
    } state_t;

    typedef struct packed {
        state_t      state;
        logic [31:0] instr;
    } dbg_t;

    // A halfword position is usable only if the whole immediate lands inside the datapath.
    function automatic logic hw_in_range(logic [1:0] hw, int data_width, int imm_width);
        return ((int'(hw) + 1) * imm_width) <= data_width;
    endfunction

endpackage

// File: rtl/move_wide_sequencer_if.sv
// Control-unit side bundle of the move-wide sequencer: instruction handshake
// in, datapath control fields and debug state out.
interface move_wide_sequencer_if
    import cu_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int RA_WIDTH   = 5
) ();

    // Handshake: an instruction is taken on a rising clock edge where start=1
    // and busy=0; start while busy=1 is dropped, not queued. stall=1 freezes a
    // sequence in progress and suppresses its side effects for that cycle.
    logic                  start;
    logic [31:0]           instr;
    logic                  stall;
    logic                  busy;
    logic                  done;
    logic                  illegal;
    logic [DATA_WIDTH-1:0] k;
    logic                  alu_en;
    logic                  alu_bs;
    logic [4:0]            alu_fs;
    logic [RA_WIDTH-1:0]   rf_sa;
    logic [RA_WIDTH-1:0]   rf_sb;
    logic [RA_WIDTH-1:0]   rf_da;
    logic                  rf_w;
    logic [1:0]            pc_fs;
    logic                  status_ld;
    dbg_t                  dbg;

    modport master (
        output start, instr, stall,
        input  busy, done, illegal, k, alu_en, alu_bs, alu_fs,
               rf_sa, rf_sb, rf_da, rf_w, pc_fs, status_ld, dbg
    );

    modport slave (
        input  start, instr, stall,
        output busy, done, illegal, k, alu_en, alu_bs, alu_fs,
               rf_sa, rf_sb, rf_da, rf_w, pc_fs, status_ld, dbg
    );

endinterface

// File: rtl/move_wide_sequencer_shifter.sv
// Places the immediate at its halfword position and builds the keep-mask
// that clears exactly that halfword.
module wide_imm_shifter #(
    parameter int DATA_WIDTH = 64,
    parameter int IMM_WIDTH  = 16
) (
    input  logic [IMM_WIDTH-1:0]  imm,
    input  logic [1:0]            hw,
    output logic [DATA_WIDTH-1:0] sh,
    output logic [DATA_WIDTH-1:0] msk
);

    logic [31:0]           shamt;
    logic [DATA_WIDTH-1:0] imm_ext;
    logic [DATA_WIDTH-1:0] ones_ext;

    assign shamt    = 32'(hw) * 32'(IMM_WIDTH);
    assign imm_ext  = DATA_WIDTH'(imm);
    assign ones_ext = DATA_WIDTH'({IMM_WIDTH{1'b1}});

    assign sh  = imm_ext << shamt;
    assign msk = ~(ones_ext << shamt);

endmodule

// File: rtl/move_wide_sequencer.sv
// Multi-cycle sequencer for MOVZ/MOVN/MOVK: owns the step state and drives
// ALU, register-file and PC control plus the K constant, one step per cycle.
module move_wide_sequencer
    import cu_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int IMM_WIDTH  = 16,
    parameter int RA_WIDTH   = 5
) (
    input logic                  clock,
    input logic                  reset,
    move_wide_sequencer_if.slave bus
);

    localparam logic [RA_WIDTH-1:0] ZR = '1;

    state_t      state;
    logic [31:0] instr_q;

    logic [1:0]            in_opc;
    logic [1:0]            in_hw;
    logic [1:0]            opc_q;
    logic [1:0]            hw_q;
    logic [IMM_WIDTH-1:0]  imm_q;
    logic [RA_WIDTH-1:0]   rd_q;
    logic [DATA_WIDTH-1:0] sh;
    logic [DATA_WIDTH-1:0] msk;

    assign in_opc = bus.instr[30:29];
    assign in_hw  = bus.instr[22:21];
    assign opc_q  = instr_q[30:29];
    assign hw_q   = instr_q[22:21];
    assign imm_q  = instr_q[5 +: IMM_WIDTH];
    assign rd_q   = instr_q[RA_WIDTH-1:0];

    wide_imm_shifter #(
        .DATA_WIDTH(DATA_WIDTH),
        .IMM_WIDTH (IMM_WIDTH)
    ) u_shifter (
        .imm(imm_q),
        .hw (hw_q),
        .sh (sh),
        .msk(msk)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            instr_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        instr_q <= bus.instr;
                        if (in_opc == OPC_RSVD || !hw_in_range(in_hw, DATA_WIDTH, IMM_WIDTH))
                            state <= S_ERROR;
                        else if (in_opc == OPC_MOVK)
                            state <= S_MASK;
                        else
                            state <= S_INSERT;
                    end
                end
                S_MASK:   if (!bus.stall) state <= S_INSERT;
                S_INSERT: if (!bus.stall) state <= S_IDLE;
                // ERROR has no side effects to hold back, so it never waits on stall.
                S_ERROR:  state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    logic                  done_d;
    logic                  illegal_d;
    logic [DATA_WIDTH-1:0] k_d;
    logic                  alu_en_d;
    logic                  alu_bs_d;
    logic [4:0]            alu_fs_d;
    logic [RA_WIDTH-1:0]   rf_sa_d;
    logic [RA_WIDTH-1:0]   rf_sb_d;
    logic [RA_WIDTH-1:0]   rf_da_d;
    logic                  rf_w_d;
    logic [1:0]            pc_fs_d;

    always_comb begin
        done_d    = 1'b0;
        illegal_d = 1'b0;
        k_d       = '0;
        alu_en_d  = 1'b0;
        alu_bs_d  = 1'b0;
        alu_fs_d  = ALU_FS_AND;
        rf_sa_d   = '0;
        rf_sb_d   = '0;
        rf_da_d   = '0;
        rf_w_d    = 1'b0;
        pc_fs_d   = PC_FS_HOLD;
        case (state)
            S_MASK: begin
                k_d      = msk;
                alu_en_d = 1'b1;
                alu_bs_d = 1'b1;
                alu_fs_d = ALU_FS_AND;
                rf_sa_d  = rd_q;
                rf_sb_d  = ZR;
                rf_da_d  = rd_q;
                rf_w_d   = 1'b1;
            end
            S_INSERT: begin
                alu_en_d = 1'b1;
                alu_bs_d = 1'b1;
                alu_fs_d = ALU_FS_OR;
                rf_sb_d  = ZR;
                rf_da_d  = rd_q;
                rf_w_d   = 1'b1;
                pc_fs_d  = PC_FS_INC;
                done_d   = 1'b1;
                // MOVK merges into Rd; MOVZ/MOVN build the value from XZR.
                rf_sa_d  = (opc_q == OPC_MOVK) ? rd_q : ZR;
                k_d      = (opc_q == OPC_MOVN) ? ~sh : sh;
            end
            S_ERROR:  illegal_d = 1'b1;
            default:  ;
        endcase
        if (bus.stall) begin
            rf_w_d  = 1'b0;
            pc_fs_d = PC_FS_HOLD;
            done_d  = 1'b0;
        end
    end

    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = done_d;
    assign bus.illegal   = illegal_d;
    assign bus.k         = k_d;
    assign bus.alu_en    = alu_en_d;
    assign bus.alu_bs    = alu_bs_d;
    assign bus.alu_fs    = alu_fs_d;
    assign bus.rf_sa     = rf_sa_d;
    assign bus.rf_sb     = rf_sb_d;
    assign bus.rf_da     = rf_da_d;
    assign bus.rf_w      = rf_w_d;
    assign bus.pc_fs     = pc_fs_d;
    assign bus.status_ld = 1'b0;
    assign bus.dbg       = '{state: state, instr: instr_q};

endmodule

// File: tb/tb_move_wide_sequencer.sv
// Directed bench for move_wide_sequencer: 64-bit and 32-bit instances, a
// per-cycle vector table, a small register-file model and corner sequences.
module tb_move_wide_sequencer;
    import cu_pkg::*;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    move_wide_sequencer_if #(.DATA_WIDTH(64), .RA_WIDTH(5)) if64 ();
    move_wide_sequencer_if #(.DATA_WIDTH(32), .RA_WIDTH(5)) if32 ();

    move_wide_sequencer #(.DATA_WIDTH(64), .IMM_WIDTH(16), .RA_WIDTH(5)) dut64 (
        .clock(clock),
        .reset(reset),
        .bus  (if64.slave)
    );

    move_wide_sequencer #(.DATA_WIDTH(32), .IMM_WIDTH(16), .RA_WIDTH(5)) dut32 (
        .clock(clock),
        .reset(reset),
        .bus  (if32.slave)
    );

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        illegal;
        logic        alu_en;
        logic        alu_bs;
        logic [4:0]  alu_fs;
        logic [4:0]  rf_sa;
        logic [4:0]  rf_sb;
        logic [4:0]  rf_da;
        logic        rf_w;
        logic [1:0]  pc_fs;
        logic        status_ld;
        logic [63:0] k;
    } obs_t;

    typedef struct packed {
        logic        start;
        logic [31:0] instr;
        logic        stall;
        obs_t        exp;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;
    int n_writes = 0;
    vec_t tbl[$];

    // Register-file model for the 64-bit datapath; X3 preloaded for the MOVK case.
    logic [63:0] rf [0:31];
    logic [63:0] rd_a;
    assign rd_a = (if64.rf_sa == ZR_ADDR) ? 64'h0 : rf[if64.rf_sa];

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= 64'h0;
            rf[3] <= 64'h1111_2222_3333_4444;
        end else if (if64.rf_w) begin
            rf[if64.rf_da] <= (if64.alu_fs == ALU_FS_AND) ? (rd_a & if64.k) : (rd_a | if64.k);
            n_writes <= n_writes + 1;
        end
    end

    function automatic logic [31:0] mk(logic [1:0] opc, logic [1:0] hw, logic [15:0] imm, logic [4:0] rd);
        return {1'b1, opc, 6'b100101, hw, imm, rd};
    endfunction

    function automatic obs_t e_idle();
        obs_t o = '0;
        return o;
    endfunction

    function automatic obs_t e_err();
        obs_t o = '0;
        o.busy    = 1'b1;
        o.illegal = 1'b1;
        return o;
    endfunction

    function automatic obs_t e_mask(logic [4:0] rd, logic [63:0] k, logic stalled);
        obs_t o = '0;
        o.busy   = 1'b1;
        o.alu_en = 1'b1;
        o.alu_bs = 1'b1;
        o.alu_fs = ALU_FS_AND;
        o.rf_sa  = rd;
        o.rf_sb  = ZR_ADDR;
        o.rf_da  = rd;
        o.rf_w   = !stalled;
        o.pc_fs  = PC_FS_HOLD;
        o.k      = k;
        return o;
    endfunction

    function automatic obs_t e_ins(logic [4:0] sa, logic [4:0] da, logic [63:0] k, logic stalled);
        obs_t o = '0;
        o.busy   = 1'b1;
        o.done   = !stalled;
        o.alu_en = 1'b1;
        o.alu_bs = 1'b1;
        o.alu_fs = ALU_FS_OR;
        o.rf_sa  = sa;
        o.rf_sb  = ZR_ADDR;
        o.rf_da  = da;
        o.rf_w   = !stalled;
        o.pc_fs  = stalled ? PC_FS_HOLD : PC_FS_INC;
        o.k      = k;
        return o;
    endfunction

    function automatic vec_t mkv(logic s, logic [31:0] ins, logic st, obs_t e);
        vec_t v;
        v.start = s;
        v.instr = ins;
        v.stall = st;
        v.exp   = e;
        return v;
    endfunction

    function automatic obs_t obs64();
        obs_t o;
        o.busy = if64.busy;   o.done = if64.done;     o.illegal = if64.illegal;
        o.alu_en = if64.alu_en; o.alu_bs = if64.alu_bs; o.alu_fs = if64.alu_fs;
        o.rf_sa = if64.rf_sa; o.rf_sb = if64.rf_sb;   o.rf_da = if64.rf_da;
        o.rf_w = if64.rf_w;   o.pc_fs = if64.pc_fs;   o.status_ld = if64.status_ld;
        o.k = if64.k;
        return o;
    endfunction

    function automatic obs_t obs32();
        obs_t o;
        o.busy = if32.busy;   o.done = if32.done;     o.illegal = if32.illegal;
        o.alu_en = if32.alu_en; o.alu_bs = if32.alu_bs; o.alu_fs = if32.alu_fs;
        o.rf_sa = if32.rf_sa; o.rf_sb = if32.rf_sb;   o.rf_da = if32.rf_da;
        o.rf_w = if32.rf_w;   o.pc_fs = if32.pc_fs;   o.status_ld = if32.status_ld;
        o.k = {32'h0, if32.k};
        return o;
    endfunction

    task automatic check_obs(input string name, input obs_t act, input obs_t exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive on the falling edge, compare 1 time unit later, before the next rising edge.
    task automatic apply(input vec_t v, input string name, input bit use32);
        @(negedge clock);
        if (use32) begin
            if32.start = v.start; if32.instr = v.instr; if32.stall = v.stall;
        end else begin
            if64.start = v.start; if64.instr = v.instr; if64.stall = v.stall;
        end
        #1;
        check_obs(name, use32 ? obs32() : obs64(), v.exp);
    endtask

    initial begin
        int wr_before;
        reset = 1'b1;
        if64.start = 1'b0; if64.instr = '0; if64.stall = 1'b0;
        if32.start = 1'b0; if32.instr = '0; if32.stall = 1'b0;
        @(negedge clock);
        #1;
        check_obs("reset_state64", obs64(), e_idle());
        check_obs("reset_state32", obs32(), e_idle());
        @(negedge clock);
        reset = 1'b0;

        // MOVK hw=1 imm=BEEF into X3
        tbl.push_back(mkv(1'b0, 32'h0, 1'b0, e_idle()));
        tbl.push_back(mkv(1'b1, mk(OPC_MOVK, 2'd1, 16'hBEEF, 5'd3), 1'b0, e_idle()));
        tbl.push_back(mkv(1'b0, 32'h0, 1'b0, e_mask(5'd3, 64'hFFFF_FFFF_0000_FFFF, 1'b0)));
        tbl.push_back(mkv(1'b0, 32'h0, 1'b0, e_ins(5'd3, 5'd3, 64'h0000_0000_BEEF_0000, 1'b0)));
        tbl.push_back(mkv(1'b0, 32'h0, 1'b0, e_idle()));
        // MOVZ hw=3, started while stall is high in IDLE
        tbl.push_back(mkv(1'b1, mk(OPC_MOVZ, 2'd3, 16'h1234, 5'd5), 1'b1, e_idle()));
        tbl.push_back(mkv(1'b0, 32'h0, 1'b0, e_ins(ZR_ADDR, 5'd5, 64'h1234_0000_0000_0000, 1'b0)));
        tbl.push_back(mkv(1'b0, 32'h0, 1'b0, e_idle()));
        // MOVN hw=0 imm=1 with one stalled INSERT cycle
        tbl.push_back(mkv(1'b1, mk(OPC_MOVN, 2'd0, 16'h0001, 5'd7), 1'b0, e_idle()));
        tbl.push_back(mkv(1'b0, 32'h0, 1'b1, e_ins(ZR_ADDR, 5'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1)));
        tbl.push_back(mkv(1'b0, 32'h0, 1'b0, e_ins(ZR_ADDR, 5'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0)));
        tbl.push_back(mkv(1'b0, 32'h0, 1'b0, e_idle()));
        // start while busy must be dropped
        tbl.push_back(mkv(1'b1, mk(OPC_MOVZ, 2'd0, 16'hAAAA, 5'd2), 1'b0, e_idle()));
        tbl.push_back(mkv(1'b1, mk(OPC_MOVK, 2'd1, 16'h5555, 5'd9), 1'b0,
                          e_ins(ZR_ADDR, 5'd2, 64'h0000_0000_0000_AAAA, 1'b0)));
        tbl.push_back(mkv(1'b0, 32'h0, 1'b0, e_idle()));
        tbl.push_back(mkv(1'b0, 32'h0, 1'b0, e_idle()));
        // reserved opcode 01
        tbl.push_back(mkv(1'b1, mk(OPC_RSVD, 2'd0, 16'h1234, 5'd6), 1'b0, e_idle()));
        tbl.push_back(mkv(1'b0, 32'h0, 1'b0, e_err()));
        tbl.push_back(mkv(1'b0, 32'h0, 1'b0, e_idle()));

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], $sformatf("tbl%0d", i), 1'b0);

        check_val("x3_movk", rf[3], 64'h1111_2222_BEEF_4444);
        check_val("x5_movz", rf[5], 64'h1234_0000_0000_0000);
        check_val("x7_movn", rf[7], 64'hFFFF_FFFF_FFFF_FFFE);
        check_val("x2_movz", rf[2], 64'h0000_0000_0000_AAAA);
        check_val("x9_ignored", rf[9], 64'h0);
        check_val("x6_illegal", rf[6], 64'h0);
        check_val("table_writes", 64'(n_writes), 64'd5);

        // MOVK hw=2 with three stalled MASK cycles
        wr_before = n_writes;
        apply(mkv(1'b1, mk(OPC_MOVK, 2'd2, 16'h00FF, 5'd4), 1'b0, e_idle()), "stall_start", 1'b0);
        for (int i = 0; i < 3; i++)
            apply(mkv(1'b0, 32'h0, 1'b1, e_mask(5'd4, 64'hFFFF_0000_FFFF_FFFF, 1'b1)),
                  $sformatf("stall_mask%0d", i), 1'b0);
        apply(mkv(1'b0, 32'h0, 1'b0, e_mask(5'd4, 64'hFFFF_0000_FFFF_FFFF, 1'b0)), "stall_resume", 1'b0);
        apply(mkv(1'b0, 32'h0, 1'b0, e_ins(5'd4, 5'd4, 64'h0000_00FF_0000_0000, 1'b0)), "stall_insert", 1'b0);
        apply(mkv(1'b0, 32'h0, 1'b0, e_idle()), "stall_end", 1'b0);
        check_val("stall_writes", 64'(n_writes - wr_before), 64'd2);
        check_val("x4_movk", rf[4], 64'h0000_00FF_0000_0000);

        // reset while in MASK, then a normal instruction
        apply(mkv(1'b1, mk(OPC_MOVK, 2'd0, 16'h7777, 5'd8), 1'b0, e_idle()), "rst_start", 1'b0);
        apply(mkv(1'b0, 32'h0, 1'b0, e_mask(5'd8, 64'hFFFF_FFFF_FFFF_0000, 1'b0)), "rst_mask", 1'b0);
        check_val("rst_dbg_mask", 64'(if64.dbg.state), 64'(S_MASK));
        #2 reset = 1'b1;
        #1;
        check_obs("rst_async", obs64(), e_idle());
        check_val("rst_dbg_idle", 64'(if64.dbg.state), 64'(S_IDLE));
        @(negedge clock);
        reset = 1'b0;
        apply(mkv(1'b1, mk(OPC_MOVZ, 2'd1, 16'h00C3, 5'd8), 1'b0, e_idle()), "post_rst_start", 1'b0);
        apply(mkv(1'b0, 32'h0, 1'b0, e_ins(ZR_ADDR, 5'd8, 64'h0000_0000_00C3_0000, 1'b0)), "post_rst_ins", 1'b0);
        apply(mkv(1'b0, 32'h0, 1'b0, e_idle()), "post_rst_end", 1'b0);
        check_val("x8_post_rst", rf[8], 64'h0000_0000_00C3_0000);

        // 32-bit instance: hw=2 is out of range, hw=1 is the top halfword
        apply(mkv(1'b1, mk(OPC_MOVZ, 2'd2, 16'h1234, 5'd1), 1'b0, e_idle()), "w32_hw2_start", 1'b1);
        apply(mkv(1'b0, 32'h0, 1'b0, e_err()), "w32_hw2_err", 1'b1);
        apply(mkv(1'b0, 32'h0, 1'b0, e_idle()), "w32_hw2_end", 1'b1);
        apply(mkv(1'b1, mk(OPC_MOVZ, 2'd1, 16'hABCD, 5'd1), 1'b0, e_idle()), "w32_movz_start", 1'b1);
        apply(mkv(1'b0, 32'h0, 1'b0, e_ins(ZR_ADDR, 5'd1, 64'h0000_0000_ABCD_0000, 1'b0)), "w32_movz_ins", 1'b1);
        apply(mkv(1'b1, mk(OPC_MOVK, 2'd1, 16'h0001, 5'd2), 1'b0, e_idle()), "w32_movk_start", 1'b1);
        apply(mkv(1'b0, 32'h0, 1'b0, e_mask(5'd2, 64'h0000_0000_0000_FFFF, 1'b0)), "w32_movk_mask", 1'b1);
        apply(mkv(1'b0, 32'h0, 1'b0, e_ins(5'd2, 5'd2, 64'h0000_0000_0001_0000, 1'b0)), "w32_movk_ins", 1'b1);
        apply(mkv(1'b1, mk(OPC_MOVN, 2'd1, 16'h0000, 5'd3), 1'b0, e_idle()), "w32_movn_start", 1'b1);
        apply(mkv(1'b0, 32'h0, 1'b0, e_ins(ZR_ADDR, 5'd3, 64'h0000_0000_FFFF_FFFF, 1'b0)), "w32_movn_ins", 1'b1);
        apply(mkv(1'b0, 32'h0, 1'b0, e_idle()), "w32_end", 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
